acc_requant_pack_i8: RTL
========================

Name: acc_requant_pack_i8

Overview:
- Output-side counterpart of the packed-INT8 MAC datapath. The MAC unpacks four INT8 lanes from a 32-bit word and accumulates them into INT32; this block takes a stream of INT32 accumulator results and converts them back.
- Each result is requantised (arithmetic shift, zero-point add, saturate to INT8). Four results are packed into one 32-bit word for register-file or memory writeback.
- Lane order matches the MAC unpack order: lane0 = bits[7:0] … lane3 = bits[31:24].

Parameters:
- ACC_W, 32, accumulator input width (signed).
- SHIFT_W, 5, width of the shift-amount input; legal shift range 0..2^SHIFT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_acc  in  ACC_W  signed accumulator value.
- in_last  in  1  final value of the stream; forces a partial word out.
- shift  in  SHIFT_W  right-shift amount, sampled per accepted beat.
- zero_point  in  8  signed INT8 output zero point, sampled per accepted beat.
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  32  packed INT8 lanes.
- out_mask  out  4  per-lane valid mask.
- out_last  out  1  word closed by in_last.
- busy  out  1  lane_cnt != 0 or out_valid.

Behaviour:
- Reset: lane_cnt=0, pack_reg=0, out_valid=0, out_data=0, out_mask=0, out_last=0, busy=0.
- Reset takes effect immediately. A word partially filled mid-operation is discarded. Reset has priority over every other event.
- Requantisation (combinational, per beat):
  - t = in_acc >>> shift, arithmetic shift, sign preserved.
  - u = t + sign-extended zero_point, computed at ACC_W+1 bits so it cannot overflow.
  - y = sat(u) to [-128, 127].
- Lane write: on an accepted beat, y is written into pack_reg lane[lane_cnt].
- Word close: the word closes when lane_cnt==3 or in_last==1. On close:
  - The output register loads {y merged into pack_reg}.
  - out_mask = bits 0..lane_cnt set.
  - out_last = in_last.
  - out_valid is set to 1.
  - lane_cnt returns to 0 and pack_reg clears to 0.
  - Unwritten lanes of a partial word read 0x00.
- Otherwise an accepted beat only increments lane_cnt.
- Latency: the word is visible on out_data the cycle after its closing beat is accepted.
- Handshake:
  - in_ready = !out_valid || out_ready. A single output holding register permits full throughput: 1 beat/cycle in, 1 word per 4 cycles out.
  - out_valid, out_data, out_mask and out_last are held stable while out_valid && !out_ready.
  - A simultaneous output pop and closing input beat is legal; the new word replaces the old one in the same cycle and out_valid stays 1.
  - A pop with no closing beat clears out_valid.
- Boundary cases:
  - in_last on lane 3 gives mask 0xF with out_last=1.
  - in_last on lane 0 gives mask 0x1.
  - No accepted beat means no state change.
  - shift=0 passes the value through unchanged.
  - Maximum shift on a negative value gives -1.
- A non-power-of-two lane count is not supported; LANES is fixed at 4.

Optional Feature:
- Macro REQUANT_ROUND_EN.
- Defined: round-half-up before the shift. When shift>0, add 2^(shift-1) in ACC_W+1 bits before >>>. shift=0 is unaffected.
- Undefined: pure truncating arithmetic shift (floor).
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package ai_pkg:
  - INT8_MIN=-128, INT8_MAX=127, LANE_W=8, LANES=4.
  - Typedef for a packed int8x4 word.
  - Function sat_i8. The MAC unpack logic shares the same lane constants.
- Sub-module requant_i8: purely combinational (in_acc, shift, zero_point -> y). The round option lives inside it.
- acc_requant_pack_i8 holds lane_cnt, pack_reg, the output register and the handshake.

Test Plan:
- Basic packing and saturation: shift=0, zp=0, acc 100, 200, -300, 5, out_ready=1 -> out_data=0x05807F64, mask=0xF, out_last=0, out_valid one cycle after the 4th beat.
- Truncating shift: shift=4, acc=344 then -24 (plus two further beats) -> without round, lane0=0x15 and lane1=0xFE. With REQUANT_ROUND_EN, lane0=0x16 and lane1=0xFF.
- Zero-point saturation: zp=10, acc=120 -> 0x7F. zp=-10, acc=-125 -> 0x80.
- Partial word: acc 1, 2 with in_last on the 2nd beat -> out_data=0x00000201, mask=0x3, out_last=1. The next stream starts at lane0.
- Backpressure: hold out_ready=0 after word 1 completes -> in_ready=0, word 1 stable for 10 cycles. Raise out_ready together with a pending closing beat -> word 2 appears the next cycle with no beat lost or duplicated.
- Reset mid-word: accept 2 beats, then assert rst -> out_valid=0, busy=0 immediately. The following 4 beats produce a word that does not contain the pre-reset lanes.

Source files
------------

// File: rtl/ai_pkg.sv
// ai_pkg: shared INT8 lane constants, packed int8x4 word type and INT8 saturation
package ai_pkg;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
  localparam int LANE_W = 8;
  localparam int LANES = 4;
  typedef logic [LANES-1:0][LANE_W-1:0] int8x4_t;
  function automatic logic [LANE_W-1:0] sat_i8(input logic signed [63:0] v);
    return v < 64'(INT8_MIN) ? 8'h80 : v > 64'(INT8_MAX) ? 8'h7f : v[LANE_W-1:0];
  endfunction
endpackage

// File: rtl/acc_requant_pack_i8_if.sv
// acc_requant_pack_i8_if: accumulator input stream and packed INT8 output stream; master = producer/consumer side, slave = packer
interface acc_requant_pack_i8_if #(parameter int ACC_W = 32, parameter int SHIFT_W = 5);
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic signed [ACC_W-1:0] in_acc;
  logic [SHIFT_W-1:0] shift;
  logic signed [7:0] zero_point;
  logic [31:0] out_data;
  logic [3:0] out_mask;
  modport master(output in_valid, in_acc, in_last, shift, zero_point, out_ready,
                 input in_ready, out_valid, out_data, out_mask, out_last);
  modport slave(input in_valid, in_acc, in_last, shift, zero_point, out_ready,
                output in_ready, out_valid, out_data, out_mask, out_last);
endinterface

// File: rtl/acc_requant_pack_i8_requant.sv
// requant_i8: combinational in_acc >>> shift + zero_point, saturated to INT8 (ports in_acc, shift, zero_point -> y); REQUANT_ROUND_EN adds round-half-up
module requant_i8 import ai_pkg::*; #(parameter int ACC_W = 32, parameter int SHIFT_W = 5) (
  input  logic signed [ACC_W-1:0] in_acc,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic signed [7:0]       zero_point,
  output logic [7:0]              y
);
  logic signed [ACC_W:0] ext, a, t, u;
  assign ext = {in_acc[ACC_W-1], in_acc};
`ifdef REQUANT_ROUND_EN
  logic signed [ACC_W:0] rnd;
  assign rnd = shift == '0 ? '0 : {{ACC_W{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
  assign a = ext + rnd;
`else
  assign a = ext;
`endif
  assign t = a >>> shift;
  // one guard bit above ACC_W keeps the zero-point add from wrapping before saturation
  assign u = t + {{(ACC_W-7){zero_point[7]}}, zero_point};
  assign y = sat_i8(64'(u));
endmodule

// File: rtl/acc_requant_pack_i8.sv
// acc_requant_pack_i8: requantises INT32 accumulators to INT8 and packs 4 lanes per word (clk, rst async high, bus slave, busy); macro REQUANT_ROUND_EN selects rounding
module acc_requant_pack_i8 import ai_pkg::*; #(parameter int ACC_W = 32, parameter int SHIFT_W = 5) (
  input  logic                 clk,
  input  logic                 rst,
  acc_requant_pack_i8_if.slave bus,
  output logic                 busy
);
  logic [1:0] lane_cnt;
  int8x4_t pack_reg, merged;
  logic [7:0] y;
  logic take, close, pop;
  requant_i8 #(.ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_rq (
    .in_acc(bus.in_acc), .shift(bus.shift), .zero_point(bus.zero_point), .y(y)
  );
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign take = bus.in_valid && bus.in_ready;
  assign close = take && (lane_cnt == 2'd3 || bus.in_last);
  assign pop = bus.out_valid && bus.out_ready;
  assign busy = lane_cnt != 2'd0 || bus.out_valid;
  always_comb begin
    merged = pack_reg;
    merged[lane_cnt] = y;
  end
  // a closing beat reloads the holding register even while popping, so out_valid stays high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lane_cnt <= '0;
      pack_reg <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_mask <= '0;
      bus.out_last <= 1'b0;
    end else if (close) begin
      lane_cnt <= '0;
      pack_reg <= '0;
      bus.out_valid <= 1'b1;
      bus.out_data <= merged;
      bus.out_mask <= 4'((5'd2 << lane_cnt) - 5'd1);
      bus.out_last <= bus.in_last;
    end else begin
      if (take) begin
        pack_reg <= merged;
        lane_cnt <= lane_cnt + 2'd1;
      end
      if (pop) bus.out_valid <= 1'b0;
    end
endmodule
